data_sram_confreg_resp: RTL

- Responder for the CPU data-SRAM interface: the memory-side end of data_sram_en/wen/addr/wdata/rdata.
- Serves byte-enabled word reads and writes from an internal word-addressed RAM.
- Also decodes a memory-mapped configuration-register window: LED, seven-segment number, switch input, free-running timer and simulation flag.
- Sits in the SoC top, beside the CPU top, wired directly to the CPU data-SRAM ports. It has a fixed 1-cycle read latency and no stall, matching what the CPU pipeline expects.

---
 rtl/data_sram_confreg_resp.sv | 117 +++++++++++
 1 files changed

// File: rtl/data_sram_confreg_resp.sv
// Memory-side responder for the CPU data-SRAM port: word RAM plus a small confreg window
// (timer, LED, switch, seven-segment number, simulation flag). Fixed 1-cycle read latency.
module data_sram_confreg_resp #(
  parameter int unsigned RAM_AW    = 16,
  parameter logic [31:0] SIMU_FLAG = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [7:0]  switch,
  output logic [15:0] led,
  output logic [31:0] num
);

  localparam logic [15:0] OffTimer  = 16'hE000;
  localparam logic [15:0] OffLed    = 16'hF020;
  localparam logic [15:0] OffSwitch = 16'hF030;
  localparam logic [15:0] OffNum    = 16'hF050;
  localparam logic [15:0] OffSimu   = 16'hFFF4;

  function automatic logic [31:0] f_merge(input logic [31:0] old_val,
                                          input logic [31:0] new_val,
                                          input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  logic [31:0] r_ram [0:(1 << RAM_AW) - 1];
  logic [31:0] r_rdata;
  logic [15:0] r_led;
  logic [31:0] r_num;
  logic [31:0] r_timer;

  logic              w_conf;
  logic [15:0]       w_off;
  logic [RAM_AW-1:0] w_idx;
  logic              w_wr;
  logic              w_rd;
  logic              w_conf_wr;
  logic [31:0]       w_rd_data;
  logic [31:0]       w_timer_d;
  logic              w_unused_addr;

  assign w_conf        = (data_sram_addr[31:16] == 16'hBFAF);
  assign w_off         = data_sram_addr[15:0];
  assign w_idx         = data_sram_addr[RAM_AW+1:2];
  assign w_wr          = data_sram_en & (|data_sram_wen);
  assign w_rd          = data_sram_en & ~(|data_sram_wen);
  assign w_conf_wr     = w_wr & w_conf;
  assign w_unused_addr = ^data_sram_addr[1:0];

  // Pre-edge view of the selected word; RAM and registers update only at the edge.
  always_comb begin
    w_rd_data = '0;
    if (w_conf) begin
      case (w_off)
        OffTimer:  w_rd_data = r_timer;
        OffLed:    w_rd_data = {16'h0000, r_led};
        OffSwitch: w_rd_data = {24'h00_0000, switch};
        OffNum:    w_rd_data = r_num;
        OffSimu:   w_rd_data = SIMU_FLAG;
        default:   w_rd_data = '0;
      endcase
    end else begin
      w_rd_data = r_ram[w_idx];
    end
  end

  // A timer write replaces the increment for that one edge.
  always_comb begin
    w_timer_d = r_timer + 32'd1;
    if (w_conf_wr && (w_off == OffTimer)) begin
      w_timer_d = f_merge(r_timer, data_sram_wdata, data_sram_wen);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata <= '0;
      r_led   <= 16'hFFFF;
      r_num   <= '0;
      r_timer <= '0;
    end else begin
      r_timer <= w_timer_d;
      if (w_rd) r_rdata <= w_rd_data;
      if (w_conf_wr && (w_off == OffLed)) begin
        if (data_sram_wen[0]) r_led[7:0]  <= data_sram_wdata[7:0];
        if (data_sram_wen[1]) r_led[15:8] <= data_sram_wdata[15:8];
      end
      if (w_conf_wr && (w_off == OffNum)) begin
        r_num <= f_merge(r_num, data_sram_wdata, data_sram_wen);
      end
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (w_wr && !w_conf) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wen[i]) r_ram[w_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  assign data_sram_rdata = r_rdata;
  assign led             = r_led;
  assign num             = r_num;

endmodule
